// File: rtl/ex_elastic_pipe_pkg.sv
// ----------------------------------------------------------------------------
// ex_elastic_pipe_pkg
//   Shared constants for the execute-to-memory elastic pipe.
//   ADDRESS_LEN        : default payload width (PC / packed EX bundle).
//   EX_PIPE_STAGES     : default number of slots in the pipe.
//   EX_PIPE_MAX_STAGES : largest supported pipe depth.
//   count_valid()      : population count of a slot-valid vector.
// ----------------------------------------------------------------------------
package ex_elastic_pipe_pkg;

    localparam int unsigned ADDRESS_LEN        = 32;
    localparam int unsigned EX_PIPE_STAGES     = 2;
    localparam int unsigned EX_PIPE_MAX_STAGES = 8;

    // Number of set bits in a (zero-extended) slot-valid vector.
    function automatic int unsigned count_valid(
        input logic [EX_PIPE_MAX_STAGES-1:0] valid_bits
    );
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < EX_PIPE_MAX_STAGES; i++) begin
            if (valid_bits[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ex_elastic_pipe_if.sv
// ----------------------------------------------------------------------------
// ex_elastic_pipe_if
//   Valid/ready handshake bundle for both ends of the elastic pipe.
//   in_valid / in_ready / in_data    : upstream (execute) side.
//   out_valid / out_ready / out_data : downstream (memory) side.
//   master : the environment around the pipe (drives inputs, ready).
//   slave  : the pipe itself.
// ----------------------------------------------------------------------------
interface ex_elastic_pipe_if
    import ex_elastic_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = ADDRESS_LEN
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/ex_pipe_slot.sv
// ----------------------------------------------------------------------------
// ex_pipe_slot
//   One elastic pipeline slot: a valid bit plus a payload register.
//   clk, rst     : clock, synchronous active-low reset.
//   i_load       : take the source entry at the next edge.
//   i_flush      : drop the held entry at the next edge (beats i_load).
//   i_src_valid  : source valid bit (previous slot or pipe input).
//   i_src_data   : source payload.
//   i_next_ready : ready of the slot (or consumer) ahead of this one.
//   o_valid      : slot holds an entry.
//   o_valid_nxt  : value o_valid takes at the next edge (rst excluded).
//   o_data       : held payload.
//   o_ready      : slot can accept this cycle (empty, or emptying).
// ----------------------------------------------------------------------------
module ex_pipe_slot
    import ex_elastic_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = ADDRESS_LEN,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic              i_src_valid,
    input  logic [DATA_W-1:0] i_src_data,
    input  logic              i_next_ready,
    output logic              o_valid,
    output logic              o_valid_nxt,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ready
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_valid_nxt;
    logic              w_data_we;

    assign o_ready = !r_valid || i_next_ready;

    always_comb begin
        w_valid_nxt = r_valid;
        if (i_flush) begin
            w_valid_nxt = 1'b0;
        end else if (i_load) begin
            w_valid_nxt = i_src_valid;
        end
    end

    // Payload only moves with a real entry; bubbles leave it untouched.
    assign w_data_we = i_load && i_src_valid && !i_flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_data_we) begin
                r_data <= i_src_data;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_valid_nxt = w_valid_nxt;
    assign o_data      = r_data;

endmodule

// File: rtl/ex_elastic_pipe.sv
// ----------------------------------------------------------------------------
// ex_elastic_pipe
//   STAGES-deep elastic pipe carrying a DATA_W payload from execute toward
//   memory. Bubbles collapse: each slot advances whenever the slot ahead can
//   accept, so a downstream stall back-pressures only as far as needed.
//   clk       : clock, rising edge.
//   rst       : synchronous active-low reset (overrides freeze and flush).
//   freeze    : global hold, no slot changes and no handshake completes.
//   flush     : clear every slot at the next edge, input dropped.
//   bus       : in_* / out_* valid-ready handshake (slave modport).
//   occupancy : registered count of valid slots.
// ----------------------------------------------------------------------------
module ex_elastic_pipe
    import ex_elastic_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = ADDRESS_LEN,
    parameter int unsigned       STAGES     = EX_PIPE_STAGES,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    localparam int unsigned      OCC_W      = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    ex_elastic_pipe_if.slave bus,
    output logic [OCC_W-1:0] occupancy
);

    logic                          w_advance;
    logic [STAGES-1:0]             w_valid_nxt;
    logic [EX_PIPE_MAX_STAGES-1:0] w_valid_nxt_ext;
    logic [OCC_W-1:0]              r_occupancy;

    assign w_advance = !freeze && !flush;

    // Ready chain is built from separate per-slot nets rather than one
    // vector so each link is its own signal with no intra-vector loop.
    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic              w_ready;
        logic              w_next_ready;
        logic              w_load;
        logic              w_src_valid;
        logic [DATA_W-1:0] w_src_data;
        logic              w_v;
        logic              w_vn;
        logic [DATA_W-1:0] w_data;

        if (i == 0) begin : g_src_in
            assign w_src_valid = bus.in_valid;
            assign w_src_data  = bus.in_data;
        end else begin : g_src_prev
            assign w_src_valid = g_slot[i-1].w_v;
            assign w_src_data  = g_slot[i-1].w_data;
        end

        if (i == STAGES - 1) begin : g_rdy_out
            assign w_next_ready = bus.out_ready;
        end else begin : g_rdy_next
            assign w_next_ready = g_slot[i+1].w_ready;
        end

        assign w_load = w_ready && w_advance;

        ex_pipe_slot #(
            .DATA_W     (DATA_W),
            .RESET_DATA (RESET_DATA)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .i_load       (w_load),
            .i_flush      (flush),
            .i_src_valid  (w_src_valid),
            .i_src_data   (w_src_data),
            .i_next_ready (w_next_ready),
            .o_valid      (w_v),
            .o_valid_nxt  (w_vn),
            .o_data       (w_data),
            .o_ready      (w_ready)
        );

        assign w_valid_nxt[i] = w_vn;
    end

    assign w_valid_nxt_ext = EX_PIPE_MAX_STAGES'(w_valid_nxt);

    // Count is taken from next-state valids so it lands on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= OCC_W'(count_valid(w_valid_nxt_ext));
        end
    end

    assign occupancy     = r_occupancy;
    assign bus.in_ready  = g_slot[0].w_ready && w_advance;
    assign bus.out_valid = g_slot[STAGES-1].w_v && !freeze;
    assign bus.out_data  = g_slot[STAGES-1].w_data;

endmodule

// File: tb/tb_ex_elastic_pipe.sv
// ----------------------------------------------------------------------------
// tb_ex_elastic_pipe
//   Two pipes (STAGES=2 and STAGES=4) share one stimulus stream. Each has a
//   queue-based reference: entries in flight with an age counting unfrozen
//   edges since acceptance; the head is visible once its age reaches
//   STAGES-1, and the input side is ready whenever the pipe is not full or
//   the consumer is taking an entry.
// ----------------------------------------------------------------------------
module tb_ex_elastic_pipe;
    import ex_elastic_pipe_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       = 1'b0;
    logic        freeze    = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data   = '0;

    logic [1:0]       ov;
    logic [1:0]       ir;
    logic [1:0][31:0] od;
    logic [1:0][2:0]  oc;

    int unsigned n_vec   = 0;
    int unsigned n_err   = 0;
    logic        mon_en  = 1'b0;
    logic        end_chk = 1'b0;

    localparam logic [31:0] RD0 = 32'h0000_0000;
    localparam logic [31:0] RD1 = 32'h5A5A_0000;

    typedef struct {
        logic [31:0] data;
        int unsigned age;
    } ent_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned S  = (g == 0) ? 2 : 4;
        localparam int unsigned OW = $clog2(S + 1);
        localparam logic [31:0] RD = (g == 0) ? RD0 : RD1;

        ex_elastic_pipe_if #(.DATA_W(32)) bus ();
        logic [OW-1:0] occ;

        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.out_ready = out_ready;
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign od[g] = bus.out_data;
        assign oc[g] = 3'(occ);

        ex_elastic_pipe #(
            .DATA_W     (32),
            .STAGES     (S),
            .RESET_DATA (RD)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .freeze    (freeze),
            .flush     (flush),
            .bus       (bus),
            .occupancy (occ)
        );

        ent_t        q[$];
        logic        acc_pend = 1'b0;
        logic [31:0] acc_data = '0;
        logic        done     = 1'b0;

        // Monitor: compare visible outputs with the reference, pop on handshake.
        always @(negedge clk) begin : mon
            logic exp_ir;
            logic exp_ov;
            exp_ir = !freeze && !flush && ((q.size() < S) || out_ready);
            exp_ov = !freeze && (q.size() > 0) && (q[0].age >= S - 1);
            acc_pend = in_valid && exp_ir;
            acc_data = in_data;
            if (mon_en) begin
                chk($sformatf("s%0d_in_ready", S), 32'(bus.in_ready), 32'(exp_ir));
                chk($sformatf("s%0d_out_valid", S), 32'(bus.out_valid), 32'(exp_ov));
                chk($sformatf("s%0d_occupancy", S), 32'(occ), q.size());
                if (bus.out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("s%0d_spurious_output", S), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("s%0d_out_data", S), bus.out_data, q[0].data);
                        void'(q.pop_front());
                    end
                end
                if (end_chk && !done) begin
                    chk($sformatf("s%0d_drained", S), q.size(), 32'd0);
                    done = 1'b1;
                end
            end
        end

        // Reference state update at the clock edge.
        always @(posedge clk) begin
            if (!rst || flush) begin
                q.delete();
            end else if (!freeze) begin
                foreach (q[j]) q[j].age = q[j].age + 1;
                if (acc_pend) q.push_back('{data: acc_data, age: 0});
            end
            acc_pend = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] peak;
        logic       exp_v;

        // 1: reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("t1_out_valid", 32'(ov[0]), 32'd0);
        chk("t1_occupancy", 32'(oc[0]), 32'd0);
        chk("t1_out_data", od[0], RD0);
        chk("t1_in_ready", 32'(ir[0]), 32'd1);
        chk("t1_out_data_s4", od[1], RD1);
        cyc();

        // 2: streaming
        out_ready = 1'b1;
        peak      = '0;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 3);
            in_data  = 32'h100 + 32'(4 * k);
            @(negedge clk);
            exp_v = (k >= 2) && (k <= 4);
            chk("t2_out_valid", 32'(ov[0]), 32'(exp_v));
            if (exp_v) chk("t2_out_data", od[0], 32'h100 + 32'(4 * (k - 2)));
            if (oc[0] > peak) peak = oc[0];
            cyc();
        end
        chk("t2_peak_occ", 32'(peak), 32'd2);

        // 3: back-pressure with a bubble
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA0; cyc();
        in_valid = 1'b0; cyc();
        in_valid = 1'b1; in_data = 32'hA4;
        @(negedge clk);
        chk("t3_in_ready_room", 32'(ir[0]), 32'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_occ_full", 32'(oc[0]), 32'd2);
        chk("t3_in_ready_full", 32'(ir[0]), 32'd0);
        chk("t3_out_data_held", od[0], 32'hA0);
        cyc();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_in_ready_passthru", 32'(ir[0]), 32'd1);
        chk("t3_first_out", od[0], 32'hA0);
        cyc();
        @(negedge clk);
        chk("t3_second_valid", 32'(ov[0]), 32'd1);
        chk("t3_second_out", od[0], 32'hA4);
        cyc();

        // 4: freeze
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h200; cyc();
        in_data = 32'h204; cyc();
        freeze = 1'b1; in_data = 32'h999; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_frz_out_valid", 32'(ov[0]), 32'd0);
            chk("t4_frz_in_ready", 32'(ir[0]), 32'd0);
            chk("t4_frz_occ", 32'(oc[0]), 32'd2);
            cyc();
        end
        freeze = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t4_rel_valid", 32'(ov[0]), 32'd1);
        chk("t4_rel_data0", od[0], 32'h200);
        cyc();
        @(negedge clk);
        chk("t4_rel_data1", od[0], 32'h204);
        cyc();
        @(negedge clk);
        chk("t4_empty", 32'(oc[0]), 32'd0);

        // 5: flush during freeze
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h280; cyc();
        in_data = 32'h284; cyc();
        freeze = 1'b1; flush = 1'b1; in_data = 32'h2FF;
        @(negedge clk);
        chk("t5_flush_in_ready", 32'(ir[0]), 32'd0);
        cyc();
        freeze = 1'b0; flush = 1'b0; in_data = 32'h300; out_ready = 1'b1;
        @(negedge clk);
        chk("t5_occ_cleared", 32'(oc[0]), 32'd0);
        chk("t5_out_valid_cleared", 32'(ov[0]), 32'd0);
        chk("t5_accept_new", 32'(ir[0]), 32'd1);
        cyc();
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("t5_new_valid", 32'(ov[0]), 32'd1);
        chk("t5_new_data", od[0], 32'h300);
        cyc();

        // 6: mid-stream reset on the 4-deep pipe
        repeat (6) cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 32'h400 + 32'(4 * k); cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_occ_before", 32'(oc[1]), 32'd3);
        cyc();
        rst = 1'b0; cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_occ_after", 32'(oc[1]), 32'd0);
        chk("t6_valid_after", 32'(ov[1]), 32'd0);
        cyc();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_drain_valid", 32'(ov[1]), 32'd0);
            chk("t6_drain_data", od[1], RD1);
            cyc();
        end

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < 65);
            freeze    = ($urandom_range(0, 99) < 8);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 499) != 0);
            cyc();
        end

        rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) cyc();
        end_chk = 1'b1;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_elastic_pipe.md
Name: ex_elastic_pipe

Overview:
- Parametrised successor to the fixed single-register execute-stage path.
- A chain of STAGES elastic pipeline slots carrying a DATA_W payload (PC or a packed EX bundle) from execute toward memory.
- Adds per-slot valid bits, a valid/ready handshake, global freeze, flush and an occupancy count.
- Bubbles collapse: a slot advances whenever the slot ahead of it can accept, so stalls back-pressure only as far as needed.

Parameters:
- DATA_W, 32 (= ADDRESS_LEN): payload width in bits.
- STAGES, 2: number of register slots, legal range 1..8.
- RESET_DATA, 0: value loaded into every payload register on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- freeze  in  1  global hold; no slot changes state while high.
- flush  in  1  discards all in-flight entries (branch taken or exception).
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  this block accepts in_data this cycle.
- in_data  in  DATA_W  payload from the execute stage.
- out_valid  out  1  last slot holds a valid entry.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  DATA_W  payload of the last slot.
- occupancy  out  $clog2(STAGES+1)  number of valid slots.

Behaviour:
- State per slot i (0 = input side, STAGES-1 = output side): valid[i], data[i].
- Reset (rst==0 at an edge): all valid cleared, all data = RESET_DATA.
  - Output values after reset: out_valid=0, occupancy=0, out_data=RESET_DATA, in_ready=1 (provided freeze=0 and flush=0).
  - Reset overrides freeze and flush; reset mid-stream drops every entry with no partial output.
- Ready chain, combinational:
  - rdy[STAGES] = out_ready.
  - rdy[i] = !valid[i] | rdy[i+1].
  - in_ready = rdy[0] & !freeze & !flush.
- out_valid = valid[STAGES-1] & !freeze. out_data = data[STAGES-1] at all times.
- Transfer at the edge, when freeze=0 and flush=0:
  - Slot i loads from slot i-1 (slot 0 loads from in_data/in_valid) when rdy[i]=1.
  - Loading copies both valid and data. When the source is invalid, only valid is written (0); data holds, which reduces toggling.
  - When rdy[i]=0, slot i holds.
- Freeze=1, flush=0: every valid and data holds. in_ready=0 and out_valid=0, so no handshake completes on either side.
- Flush=1, freeze=any: every valid clears next edge; data holds; in_ready=0, so the input that cycle is dropped.
  - Flush has priority over freeze.
  - An output handshake on the flush cycle still completes if out_valid & out_ready.
- Latency and throughput:
  - Empty pipe, out_ready=1: input accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles after acceptance.
  - Sustained throughput is 1 entry/cycle.
- Full pipe with out_ready=0: in_ready=0. When out_ready rises, in_ready rises in the same cycle (combinational pass-through), so there is no lost cycle.
- Occupancy: registered popcount of valid, updated on the same edge as the valid bits. It never exceeds STAGES.
- Order is strictly FIFO; no entry is duplicated or reordered.

Decomposition:
- Shared constants package: ADDRESS_LEN, plus a default pipe-depth constant EX_PIPE_STAGES.
- Natural sub-module: ex_pipe_slot.
  - Holds one valid+data register.
  - Inputs: load, flush, src_valid, src_data.
  - Outputs: valid, data, ready given next-ready.
  - Instantiated STAGES times in a generate loop.
- Occupancy popcount and the ready chain stay in the top module.

Test Plan:
1. Reset, STAGES=2, DATA_W=32: hold rst=0 for 2 cycles, then release -> out_valid=0, occupancy=0, out_data=0, in_ready=1.
2. Streaming: send 0x100, 0x104, 0x108 on consecutive cycles with out_ready=1 -> out_valid high on cycles 2, 3, 4 after first acceptance, carrying 0x100, 0x104, 0x108 in order; occupancy peaks at 2.
3. Back-pressure and bubble collapse:
   - Load 0xA0, drop in_valid for one cycle, then load 0xA4, with out_ready=0 throughout -> both slots fill, occupancy=2, in_ready=0.
   - Raise out_ready -> in_ready=1 in the same cycle; 0xA0 is delivered, then 0xA4.
4. Freeze: pipe holds 0x200 and 0x204; assert freeze for 3 cycles with in_valid=1, out_ready=1 -> out_valid=0, in_ready=0, occupancy stays 2. After release, 0x200 is delivered next cycle with no loss or duplication.
5. Flush during freeze: pipe full; assert freeze and flush together -> next cycle occupancy=0 and out_valid=0; a new input 0x300 is accepted the cycle after flush deasserts.
6. Mid-stream reset, STAGES=4: pipe holds 3 entries; assert rst=0 for 1 cycle -> next cycle occupancy=0, out_valid=0, all payloads read RESET_DATA through drained observation.
